// File: rtl/fsk_pkg.sv
// fsk_pkg: shared FSK state type, channel encoding and default carrier periods
package fsk_pkg;
  typedef enum logic {IDLE, TRACK} state_t;
  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;
  localparam int PERIOD_A_DEF = 50;
  localparam int PERIOD_B_DEF = 25;
endpackage

// File: rtl/fsk_edge_sync.sv
// fsk_edge_sync: synchronizes an async input and emits a registered one-clk rising-edge pulse
module fsk_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic rise
);
  logic [2:0] sync_q, sync_d;
  logic rise_q, rise_d;
  always_comb begin
    sync_d = {sync_q[1:0], d_in};
    rise_d = sync_q[1] & ~sync_q[2];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
    end
  end
  assign rise = rise_q;
endmodule

// File: rtl/fsk_demod.sv
// fsk_demod: recovers bits from an FSK square wave by timing edge periods and debouncing the decision
module fsk_demod
  import fsk_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int PERIOD_A = PERIOD_A_DEF,
  parameter int PERIOD_B = PERIOD_B_DEF,
  parameter int CONFIRM  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fsk_in,
  output logic             data_out,
  output logic             bit_valid,
  output logic [CNT_W-1:0] period_meas,
  output logic             carrier_lost
);
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'((PERIOD_A + PERIOD_B) / 2);
  localparam logic [CNT_W-1:0] MIN_PER = CNT_W'(PERIOD_B / 2);
  localparam logic [CNT_W-1:0] MAX_PER = CNT_W'(2 * PERIOD_A);
  localparam int RUN_W = $clog2(CONFIRM + 1);
  if (PERIOD_B >= PERIOD_A) begin : g_chk_period
    $error("fsk_demod: PERIOD_B must be less than PERIOD_A");
  end
  if (CONFIRM < 1) begin : g_chk_confirm
    $error("fsk_demod: CONFIRM must be at least 1");
  end
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic data_q, data_d, bv_q, bv_d, lost_q, lost_d;
  logic rise, lose, accept, raw;
  fsk_edge_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .d_in (fsk_in),
    .rise (rise)
  );
  assign lose   = (state_q == TRACK) && (cnt_q == MAX_PER);
  assign accept = (state_q == TRACK) && rise && !lose && (cnt_q >= MIN_PER);
  assign raw    = (cnt_q < THRESH) ? CH_B : CH_A;
  always_comb begin
    state_d = (state_q == IDLE) ? (rise ? TRACK : IDLE) : ((lose && !rise) ? IDLE : TRACK);
    cnt_d   = (rise && (state_q == IDLE || lose || accept)) ? CNT_W'(1) :
              (cnt_q == MAX_PER) ? cnt_q : cnt_q + 1'b1;
    per_d   = accept ? cnt_q : per_q;
    bv_d    = accept;
    lost_d  = lose ? 1'b1 : accept ? 1'b0 : lost_q;
    run_d   = (lose || (accept && raw == data_q)) ? '0 :
              accept ? ((run_q == RUN_W'(CONFIRM - 1)) ? '0 : run_q + 1'b1) : run_q;
    data_d  = (accept && raw != data_q && run_q == RUN_W'(CONFIRM - 1)) ? raw : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      run_q   <= '0;
      data_q  <= 1'b0;
      bv_q    <= 1'b0;
      lost_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      run_q   <= run_d;
      data_q  <= data_d;
      bv_q    <= bv_d;
      lost_q  <= lost_d;
    end
  end
  assign data_out     = data_q;
  assign bit_valid    = bv_q;
  assign period_meas  = per_q;
  assign carrier_lost = lost_q;
endmodule

// File: tb/tb_fsk_demod.sv
// tb_fsk_demod: randomized and directed checks of fsk_demod against a period-based reference model
module tb_fsk_demod;
  import fsk_pkg::*;
  localparam int MIN_PER = 12, THRESH = 37, MAX_PER = 100, CONFIRM = 3;
  logic clk = 1'b0, rst = 1'b1, fsk_in = 1'b0;
  logic data_out, bit_valid, carrier_lost, lost_prev;
  logic [15:0] period_meas;
  int n_chk = 0, n_pass = 0, cyc = 0, lost_rise = -1;
  int bv_cyc[$], rise_cyc[$];
  bit m_trk, m_data, m_bv, m_lost = 1'b1, armed;
  int m_ref, m_run, m_pm;
  bit [4:0] h;

  fsk_demod dut (
    .clk          (clk),
    .rst          (rst),
    .fsk_in       (fsk_in),
    .data_out     (data_out),
    .bit_valid    (bit_valid),
    .period_meas  (period_meas),
    .carrier_lost (carrier_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wave(input int p, input int n, input int hi = 0);
    for (int i = 0; i < n; i++) begin
      int h0;
      h0 = (hi > 0) ? hi : p / 2;
      fsk_in = 1'b1;
      rise_cyc.push_back(cyc);
      tick(h0);
      fsk_in = 1'b0;
      tick(p - h0);
    end
  endtask

  task automatic clr();
    bv_cyc.delete();
    rise_cyc.delete();
    lost_rise = -1;
  endtask

  task automatic chk_first(input int n_exp);
    chk("pulse_count", bv_cyc.size(), n_exp);
    if (bv_cyc.size() > 0 && rise_cyc.size() > 1)
      chk("first_pulse_cycle", bv_cyc[0], rise_cyc[1] + 4);
    else
      chk("first_pulse_present", 0, 1);
  endtask

  // Reference model: an input edge sampled at clk k is seen by the block at clk k+3;
  // periods are differences between accepted edge times.
  initial begin
    int el;
    bit r, raw;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        h = '0; m_trk = 0; m_data = 0; m_bv = 0; m_lost = 1; m_run = 0; m_pm = 0; armed = 1;
      end else begin
        h = {h[3:0], fsk_in};
        r = h[3] & ~h[4];
        el = cyc - m_ref;
        m_bv = 0;
        if (!m_trk) begin
          if (r) begin m_trk = 1; m_ref = cyc; end
        end else if (el >= MAX_PER) begin
          m_lost = 1; m_run = 0;
          if (r) m_ref = cyc; else m_trk = 0;
        end else if (r && el >= MIN_PER) begin
          raw = (el < THRESH);
          m_pm = el; m_bv = 1; m_lost = 0; m_ref = cyc;
          if (raw == m_data) m_run = 0;
          else begin
            m_run++;
            if (m_run == CONFIRM) begin m_data = raw; m_run = 0; end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("data_out", data_out, m_data);
        chk("bit_valid", bit_valid, m_bv);
        chk("period_meas", period_meas, m_pm);
        chk("carrier_lost", carrier_lost, m_lost);
        if (bit_valid) bv_cyc.push_back(cyc);
        if (carrier_lost && !lost_prev) lost_rise = cyc;
        lost_prev = carrier_lost;
      end
    end
  end

  initial begin
    tick(3);
    rst = 1'b0;
    tick(300);
    chk("idle_pulses", bv_cyc.size(), 0);
    chk("idle_data", data_out, 0);
    chk("idle_lost", carrier_lost, 1);
    chk("idle_meas", period_meas, 0);
    chk("idle_state", dut.state_q, IDLE);
    clr();
    wave(50, 10);
    chk_first(9);
    for (int i = 1; i < bv_cyc.size(); i++) chk("pulse_spacing", bv_cyc[i] - bv_cyc[i-1], 50);
    chk("p50_meas", period_meas, 50);
    chk("p50_data", data_out, 0);
    chk("p50_lost", carrier_lost, 0);
    clr();
    wave(25, 3);
    chk("p25_pulses", bv_cyc.size(), 3);
    chk("p25_data_hold", data_out, 0);
    wave(25, 1);
    chk("p25_data_flip", data_out, 1);
    chk("p25_meas", period_meas, 25);
    chk("model_data_flip", m_data, 1);
    wave(50, 1); wave(25, 1); wave(50, 2); wave(25, 2);
    chk("isolated50_data", data_out, 1);
    chk("isolated50_meas", period_meas, 25);
    wave(50, 4);
    chk("back_to_a_data", data_out, 0);
    clr();
    fsk_in = 1'b1; rise_cyc.push_back(cyc); tick(5);
    fsk_in = 1'b0; tick(5);
    fsk_in = 1'b1; tick(3);
    fsk_in = 1'b0; tick(37);
    wave(50, 1);
    chk("glitch_pulses", bv_cyc.size(), 2);
    chk("glitch_meas", period_meas, 50);
    chk("glitch_data", data_out, 0);
    tick(150);
    chk("loss_cycle", lost_rise, rise_cyc[$] + 104);
    chk("loss_data_hold", data_out, 0);
    chk("loss_state", dut.state_q, IDLE);
    chk("model_lost", m_lost, 1);
    clr();
    wave(50, 3);
    chk_first(2);
    chk("restart_lost", carrier_lost, 0);
    wave(25, 5);
    chk("pre_reset_data", data_out, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_data", data_out, 0);
    chk("rst_valid", bit_valid, 0);
    chk("rst_meas", period_meas, 0);
    chk("rst_lost", carrier_lost, 1);
    clr();
    wave(25, 3);
    chk_first(2);
    for (int i = 0; i < 80; i++) begin
      int sel, p;
      sel = $urandom_range(0, 9);
      p = (sel < 4) ? 24 + $urandom_range(0, 2) :
          (sel < 8) ? 49 + $urandom_range(0, 2) :
          (sel == 8) ? $urandom_range(5, 11) : $urandom_range(101, 130);
      wave(p, 1, $urandom_range(1, p - 1));
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
    end
    tick(120);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
